// File: rtl/projeto_processador_pkg.sv
// Shared types and constants for the 16-bit multicycle lab processor.
// Opcodes, step encodings, ALU selects and the instruction ROM image.
package projeto_processador_pkg;

  typedef logic [15:0] word_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_AND  = 2'd3
  } alu_sel_t;

  function automatic word_t rom_word(input logic [4:0] a);
    word_t w;
    case (a)
      5'd0:    w = 16'h1004;
      5'd1:    w = 16'h8200;
      5'd2:    w = 16'h5209;
      5'd3:    w = 16'hA001;
      5'd4:    w = 16'h8001;
      5'd5:    w = 16'h1402;
      5'd6:    w = 16'hD401;
      5'd7:    w = 16'hE003;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/projeto_processador_alu.sv
// Combinational 16-bit ALU: pass, add, sub, and.
// Carry and borrow are dropped; results wrap modulo 2^16.
module proc_alu
  import projeto_processador_pkg::*;
(
  input  word_t    a,
  input  word_t    b,
  input  alu_sel_t select,
  output word_t    y
);

  always_comb begin
    y = b;
    unique case (select)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_PASS: y = b;
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/projeto_processador.sv
// Multicycle 16-bit processor top: step control, bus, register file,
// instruction ROM and data RAM.
module projeto_processador
  import projeto_processador_pkg::*;
#(
  parameter string ROM_INIT = "rom.mif"
)(
  input  logic [4:0] Din,
  input  logic       reset,
  input  logic       clock,
  input  logic       run,
  output logic       done
);

  step_t      Tstep_Q;
  word_t      IR;
  word_t      r0, r1, r2, r3, r4, r5, r6, r7;
  word_t      RA_out;
  word_t      G;
  word_t      BusWires;
  word_t      saidaROM;
  word_t      saidaALU;
  word_t      ramq;
  logic [4:0] ADDR;
  word_t      ram [32];
  alu_sel_t   Select;

  logic [2:0] opc, rx, ry;
  logic       imm;
  word_t      rf [8];
  word_t      rx_val, ry_val, op2;
  logic       is_mv, is_mvt, is_nop, is_alu, is_ld, is_st;
  logic       in_t0, in_t1, in_t2, in_t3;
  logic       sel_rom, sel_op2, sel_imm8, sel_rx;
  logic       sel_ry, sel_g, sel_mem, wr_rx;

  assign opc = IR[15:13];
  assign imm = IR[12];
  assign rx  = IR[11:9];
  assign ry  = IR[2:0];

  assign rf[0] = r0;
  assign rf[1] = r1;
  assign rf[2] = r2;
  assign rf[3] = r3;
  assign rf[4] = r4;
  assign rf[5] = r5;
  assign rf[6] = r6;
  assign rf[7] = r7;

  assign rx_val = rf[rx];
  assign ry_val = rf[ry];
  assign op2    = imm ? {7'd0, IR[8:0]} : ry_val;

  assign is_mv  = (opc == OP_MV);
  assign is_mvt = (opc == OP_MVT);
  assign is_nop = (opc == OP_NOP);
  assign is_ld  = (opc == OP_LD);
  assign is_st  = (opc == OP_ST);
  assign is_alu = (opc == OP_ADD) || (opc == OP_SUB)
               || (opc == OP_AND);

  assign in_t0 = (Tstep_Q == T0);
  assign in_t1 = (Tstep_Q == T1);
  assign in_t2 = (Tstep_Q == T2);
  assign in_t3 = (Tstep_Q == T3);

  assign saidaROM = rom_word(Din);

  // One-hot bus source selects; nothing selected leaves the bus at zero.
  assign sel_rom  = in_t0 & run;
  assign sel_op2  = (in_t1 & is_mv) | (in_t2 & is_alu);
  assign sel_imm8 = in_t1 & is_mvt;
  assign sel_rx   = (in_t1 & is_alu) | (in_t2 & is_st);
  assign sel_ry   = in_t1 & (is_ld | is_st);
  assign sel_g    = in_t3 & is_alu;
  assign sel_mem  = in_t3 & is_ld;

  always_comb begin
    BusWires = '0;
    unique case (1'b1)
      sel_rom:  BusWires = saidaROM;
      sel_op2:  BusWires = op2;
      sel_imm8: BusWires = {IR[7:0], 8'h00};
      sel_rx:   BusWires = rx_val;
      sel_ry:   BusWires = ry_val;
      sel_g:    BusWires = G;
      sel_mem:  BusWires = ramq;
      default:  BusWires = '0;
    endcase
  end

  always_comb begin
    Select = ALU_PASS;
    case (opc)
      OP_ADD:  Select = ALU_ADD;
      OP_SUB:  Select = ALU_SUB;
      OP_AND:  Select = ALU_AND;
      default: Select = ALU_PASS;
    endcase
  end

  proc_alu u_alu (
    .a      (RA_out),
    .b      (BusWires),
    .select (Select),
    .y      (saidaALU)
  );

  assign wr_rx = (in_t1 & (is_mv | is_mvt))
              | (in_t3 & (is_alu | is_ld));

  assign done = ~reset & (
      (in_t1 & (is_mv | is_mvt | is_nop))
    | (in_t2 & is_st)
    | (in_t3 & (is_alu | is_ld)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
      r5 <= '0;
      r6 <= '0;
      r7 <= '0;
    end else if (wr_rx) begin
      case (rx)
        3'd0:    r0 <= BusWires;
        3'd1:    r1 <= BusWires;
        3'd2:    r2 <= BusWires;
        3'd3:    r3 <= BusWires;
        3'd4:    r4 <= BusWires;
        3'd5:    r5 <= BusWires;
        3'd6:    r6 <= BusWires;
        default: r7 <= BusWires;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Tstep_Q <= T0;
      IR      <= '0;
      RA_out  <= '0;
      G       <= '0;
      ADDR    <= '0;
      ramq    <= '0;
      for (int i = 0; i < 32; i++) ram[i] <= '0;
    end else begin
      unique case (Tstep_Q)
        T0: begin
          if (run) begin
            IR      <= BusWires;
            Tstep_Q <= T1;
          end
        end
        T1: begin
          if (is_alu) RA_out <= BusWires;
          if (is_ld | is_st) ADDR <= BusWires[4:0];
          Tstep_Q <= (is_alu | is_ld | is_st) ? T2 : T0;
        end
        T2: begin
          if (is_alu) G <= saidaALU;
          if (is_ld) ramq <= ram[ADDR];
          if (is_st) ram[ADDR] <= BusWires;
          Tstep_Q <= is_st ? T0 : T3;
        end
        T3: Tstep_Q <= T0;
        default: Tstep_Q <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_projeto_processador.sv
// Scoreboard bench for projeto_processador: runs the ROM program and
// checks done latency, register results, RAM and reset behaviour.
module tb_projeto_processador;
  import projeto_processador_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [4:0] Din   = '0;
  logic       done;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    string       tag;
    int          ridx;
    logic [15:0] val;
    int          lat;
  } exp_t;

  exp_t sb[$];

  projeto_processador dut (
    .Din   (Din),
    .reset (reset),
    .clock (clock),
    .run   (run),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int i);
    case (i)
      0: return dut.r0;
      1: return dut.r1;
      2: return dut.r2;
      3: return dut.r3;
      4: return dut.r4;
      5: return dut.r5;
      6: return dut.r6;
      default: return dut.r7;
    endcase
  endfunction

  function automatic logic [15:0] step();
    return {14'd0, dut.Tstep_Q};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue one instruction, then pop its expectation when done appears.
  task automatic issue(input string tag, input logic [4:0] a,
                       input int ridx, input logic [15:0] val,
                       input int lat, input int aluv,
                       input bit tog, input bit hold);
    exp_t e;
    int   n;
    @(negedge clock);
    Din = a;
    run = 1'b1;
    sb.push_back('{tag, ridx, val, lat});
    @(posedge clock);
    #1;
    chk({tag, "_fetch"}, step(), 16'(T1));
    if (!hold) run = 1'b0;
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (aluv >= 0 && n == 2)
        chk({tag, "_alu"}, dut.saidaALU, 16'(aluv));
      if (done || n >= 10) break;
      if (tog) run = 1'($urandom_range(0, 1));
    end
    if (!hold) run = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 16'(n), 16'(e.lat));
    @(posedge clock);
    #1;
    chk({e.tag, "_reg"}, rd(e.ridx), e.val);
    chk({e.tag, "_t0"}, step(), 16'(T0));
    chk({e.tag, "_done0"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_step", step(), 16'(T0));
    for (int i = 0; i < 8; i++)
      chk($sformatf("rst_r%0d", i), rd(i), 16'd0);

    repeat (5) @(posedge clock);
    #1;
    chk("idle_step", step(), 16'(T0));
    chk("idle_ir", dut.IR, 16'd0);

    issue("mv_r0", 5'd0, 0, 16'h0004, 1, -1, 1'b0, 1'b0);
    issue("ld_r1", 5'd1, 1, 16'h0000, 3, -1, 1'b0, 1'b0);
    issue("add_r1", 5'd2, 1, 16'h0009, 3, 9, 1'b0, 1'b0);
    issue("st", 5'd3, 0, 16'h0004, 2, -1, 1'b0, 1'b0);
    chk("ram9", dut.ram[9], 16'h0004);
    issue("ld_r0", 5'd4, 0, 16'h0004, 3, -1, 1'b1, 1'b0);
    issue("mv_r2", 5'd5, 2, 16'h0002, 1, -1, 1'b0, 1'b1);
    issue("and_r2", 5'd6, 2, 16'h0000, 3, -1, 1'b0, 1'b0);
    issue("nop", 5'd7, 1, 16'h0009, 1, -1, 1'b1, 1'b0);
    chk("nop_r0", rd(0), 16'h0004);

    do_reset();
    #1;
    chk("rst2_ram9", dut.ram[9], 16'h0000);
    chk("rst2_r0", rd(0), 16'h0000);

    @(negedge clock);
    Din = 5'd2;
    run = 1'b1;
    @(posedge clock);
    #1;
    run = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("abort_at_t2", step(), 16'(T2));
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_step", step(), 16'(T0));
    chk("abort_r1", rd(1), 16'h0000);
    chk("abort_g", dut.G, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_idle", step(), 16'(T0));
    chk("abort_r1b", rd(1), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
